// File: rtl/cr_kme_drng_sched_pkg.sv
// -----------------------------------------------------------------------------
// cr_kme_drng_sched_pkg
// Shared types and widths for the KME DRNG scheduler.
//   state_e : scheduler FSM states (2 bits)
//   SEED_W  : DRNG seed width
//   LIFE_W  : seed-life counter width
//   WORD_W  : DRNG output word width
// -----------------------------------------------------------------------------
package cr_kme_drng_sched_pkg;

   localparam int SEED_W = 384;
   localparam int LIFE_W = 48;
   localparam int WORD_W = 128;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEED_REQ = 2'd1,
      START    = 2'd2,
      RUN      = 2'd3
   } state_e;

endpackage

// File: rtl/cr_kme_rr_arb.sv
// -----------------------------------------------------------------------------
// cr_kme_rr_arb
// Combinational round-robin picker. Searches eligible[] starting at ptr and
// wrapping modulo N; returns the first hit as a one-hot grant and an index.
// Ports:
//   eligible in  N  requesters allowed to win this cycle
//   ptr      in  W  highest-priority index for this search
//   grant    out N  one-hot winner (all zero when nothing is eligible)
//   winner   out W  index of the winner (0 when nothing is eligible)
// -----------------------------------------------------------------------------
module cr_kme_rr_arb #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] eligible,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] winner
);

   logic found_s;
   int   idx_s;

   // Rotating priority search from ptr; the first eligible index wins.
   always_comb begin
      grant   = '0;
      winner  = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 0; k < N; k++) begin
         idx_s = (int'(ptr) + k) % N;
         if (!found_s && eligible[idx_s]) begin
            found_s       = 1'b1;
            grant[idx_s]  = 1'b1;
            winner        = W'(idx_s);
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/cr_kme_drng_sched.sv
// -----------------------------------------------------------------------------
// cr_kme_drng_sched
// Seed controller and output scheduler for the KME AES-256 DRNG.
// Fetches seeds from the entropy source, programs and starts the DRNG,
// reseeds on expiry after draining old-seed words, and shares the DRNG
// output FIFO among N_REQ requesters round-robin, one word per grant.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   en                         enable for seed requests and grants
//   seed_life_cfg              rounds per seed, loaded with each seed
//   ent_req/ent_vld/ent_seed   entropy-source seed handshake
//   drng_start/seed/seed_life  DRNG programming
//   drng_seed_expired          DRNG expiry status
//   drng_valid/data/ack        DRNG output FIFO (ack = pop)
//   req/rsp_vld/rsp_data       requester interface (rsp_data broadcast)
//   reseed_cnt/words_cnt       saturating statistics
// -----------------------------------------------------------------------------
module cr_kme_drng_sched
   import cr_kme_drng_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int RR_W  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [LIFE_W-1:0]   seed_life_cfg,
   output logic                ent_req,
   input  logic                ent_vld,
   input  logic [SEED_W-1:0]   ent_seed,
   output logic                drng_start,
   output logic [SEED_W-1:0]   drng_seed,
   output logic [LIFE_W-1:0]   drng_seed_life,
   input  logic                drng_seed_expired,
   input  logic                drng_valid,
   input  logic [WORD_W-1:0]   drng_data,
   output logic                drng_ack,
   input  logic [N_REQ-1:0]    req,
   output logic [N_REQ-1:0]    rsp_vld,
   output logic [WORD_W-1:0]   rsp_data,
   output logic [15:0]         reseed_cnt,
   output logic [31:0]         words_cnt
);

   state_e            state_r;
   state_e            state_s;
   logic [RR_W-1:0]   rr_ptr_r;
   logic [N_REQ-1:0]  elig_s;
   logic [N_REQ-1:0]  arb_grant_s;
   logic [RR_W-1:0]   arb_winner_s;
   logic              gnt_s;
   logic              xfer_s;
   logic [RR_W-1:0]   ptr_nxt_s;

   // A requester that was just answered sits out one cycle, which caps a
   // single requester at one word every two cycles.
   assign elig_s   = req & {N_REQ{en}} & ~rsp_vld;
   assign gnt_s    = (state_r == RUN) & drng_valid & (|elig_s);
   assign xfer_s   = (state_r == SEED_REQ) & ent_vld;
   assign drng_ack = gnt_s;

   cr_kme_rr_arb #(
      .N (N_REQ),
      .W (RR_W)
   ) u_arb (
      .eligible (elig_s),
      .ptr      (rr_ptr_r),
      .grant    (arb_grant_s),
      .winner   (arb_winner_s)
   );

   // Pointer moves just past the winner, wrapping at N_REQ-1.
   always_comb begin
      ptr_nxt_s = '0;
      if (arb_winner_s == RR_W'(N_REQ - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = arb_winner_s + RR_W'(1);
      end
   end

   // Next-state logic. Reseed waits until the FIFO has drained so words
   // produced under the old seed are still delivered.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (en) begin
               state_s = SEED_REQ;
            end else begin
               state_s = IDLE;
            end
         end
         SEED_REQ: begin
            if (ent_vld) begin
               state_s = START;
            end else if (!en) begin
               state_s = IDLE;
            end else begin
               state_s = SEED_REQ;
            end
         end
         START: begin
            state_s = RUN;
         end
         RUN: begin
            if (en && drng_seed_expired && !drng_valid) begin
               state_s = SEED_REQ;
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register and state-derived registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         ent_req    <= 1'b0;
         drng_start <= 1'b0;
      end else begin
         state_r    <= state_s;
         ent_req    <= (state_s == SEED_REQ);
         drng_start <= (state_s == START);
      end
   end

   // Seed and seed-life capture; held between loads because the DRNG
   // samples them continuously while expired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drng_seed      <= '0;
         drng_seed_life <= '0;
      end else if (xfer_s) begin
         drng_seed      <= ent_seed;
         drng_seed_life <= seed_life_cfg;
      end
   end

   // Round-robin pointer and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
         rsp_vld  <= '0;
         rsp_data <= '0;
      end else if (gnt_s) begin
         rr_ptr_r <= ptr_nxt_s;
         rsp_vld  <= arb_grant_s;
         rsp_data <= drng_data;
      end else begin
         rsp_vld  <= '0;
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reseed_cnt <= 16'd0;
         words_cnt  <= 32'd0;
      end else begin
         if (xfer_s && (reseed_cnt != 16'hFFFF)) begin
            reseed_cnt <= reseed_cnt + 16'd1;
         end
         if (gnt_s && (words_cnt != 32'hFFFF_FFFF)) begin
            words_cnt <= words_cnt + 32'd1;
         end
      end
   end

endmodule
